// File: rtl/rv_mcu_eai_host.sv
// -----------------------------------------------------------------------------
// rv_mcu_eai_host
//
// Host-side model of the EAI coprocessor interface, used in the HWPE testbench
// in place of the RISC-V core. Instructions are queued, issued with a rolling
// itag, and retired in order while the tag of each response is checked. A
// word-addressed backing memory with configurable latency serves the
// coprocessor's ICB memory channel.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   push, push_instr/rs1/rs2, push_ready
//                         instruction queue enqueue side
//   eai_req_*             request channel to the coprocessor (head of queue)
//   eai_rsp_*             response channel from the coprocessor
//   eai_icb_cmd_*         memory command from the coprocessor
//   eai_icb_rsp_*         memory response to the coprocessor
//   eai_mem_holdup        coprocessor owns memory; blocks fresh requests
//   outstanding           issued and not yet retired
//   rsp_count             retired responses (wraps)
//   last_rsp_wdat         wdat of the most recently retired response
//   tag_err               sticky: response itag mismatch or spurious response
//   rsp_err_seen          sticky: a retired response carried eai_rsp_err
// -----------------------------------------------------------------------------
module rv_mcu_eai_host #(
   parameter int IQ_DEPTH     = 4,
   parameter int ITAG_W       = 2,
   parameter int MEM_AW       = 10,
   parameter int MEM_LAT      = 1,
   parameter int RSP_RDY_MODE = 0,
   parameter int CMD_RDY_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [31:0]       push_instr,
   input  logic [31:0]       push_rs1,
   input  logic [31:0]       push_rs2,
   output logic              push_ready,
   output logic              eai_req_valid,
   input  logic              eai_req_ready,
   output logic [31:0]       eai_req_instr,
   output logic [31:0]       eai_req_rs1,
   output logic [31:0]       eai_req_rs2,
   output logic [ITAG_W-1:0] eai_req_itag,
   input  logic              eai_rsp_valid,
   output logic              eai_rsp_ready,
   input  logic [31:0]       eai_rsp_wdat,
   input  logic [ITAG_W-1:0] eai_rsp_itag,
   input  logic              eai_rsp_err,
   input  logic              eai_icb_cmd_valid,
   output logic              eai_icb_cmd_ready,
   input  logic [31:0]       eai_icb_cmd_addr,
   input  logic              eai_icb_cmd_read,
   input  logic [31:0]       eai_icb_cmd_wdata,
   input  logic [3:0]        eai_icb_cmd_wmask,
   output logic              eai_icb_rsp_valid,
   input  logic              eai_icb_rsp_ready,
   output logic [31:0]       eai_icb_rsp_rdata,
   output logic              eai_icb_rsp_err,
   input  logic              eai_mem_holdup,
   output logic [ITAG_W:0]   outstanding,
   output logic [15:0]       rsp_count,
   output logic [31:0]       last_rsp_wdat,
   output logic              tag_err,
   output logic              rsp_err_seen
);

   localparam int QP_W  = $clog2(IQ_DEPTH);
   localparam int QC_W  = QP_W + 1;
   localparam int OUT_W = ITAG_W + 1;
   localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
   // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with MEM_LAT-2 and
   // leaves WAIT when it reaches zero.
   localparam logic [LAT_W-1:0] LAT_LOAD = (MEM_LAT >= 2) ? LAT_W'(MEM_LAT - 2) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RSP
   } mem_state_t;

   // ---------------------------------------------------------------- queue --
   logic [31:0]     r_q_instr [IQ_DEPTH];
   logic [31:0]     r_q_rs1   [IQ_DEPTH];
   logic [31:0]     r_q_rs2   [IQ_DEPTH];
   logic [QP_W-1:0] r_wr_ptr;
   logic [QP_W-1:0] r_rd_ptr;
   logic [QC_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push_acc;
   logic w_req_hs;

   assign w_full     = (r_count == QC_W'(IQ_DEPTH));
   assign w_empty    = (r_count == '0);
   // No bypass: a pop in the same cycle does not make room for a push.
   assign w_push_acc = push & ~w_full;
   assign push_ready = ~w_full;

   assign eai_req_instr = r_q_instr[r_rd_ptr];
   assign eai_req_rs1   = r_q_rs1[r_rd_ptr];
   assign eai_req_rs2   = r_q_rs2[r_rd_ptr];

   // NOTE: storage arrays carry no reset; occupancy is tracked by the pointers
   // and count, so stale entries are never observed and the array maps to RAM.
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_q_instr[r_wr_ptr] <= push_instr;
         r_q_rs1[r_wr_ptr]   <= push_rs1;
         r_q_rs2[r_wr_ptr]   <= push_rs2;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + QP_W'(1);
         if (w_req_hs)   r_rd_ptr <= r_rd_ptr + QP_W'(1);
         case ({w_push_acc, w_req_hs})
            2'b10:   r_count <= r_count + QC_W'(1);
            2'b01:   r_count <= r_count - QC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------ issue / retire --
   logic [ITAG_W-1:0] r_issue_tag;
   logic [ITAG_W-1:0] r_retire_tag;
   logic [OUT_W-1:0]  r_outstanding;
   logic              r_req_hold;
   logic [15:0]       r_rsp_count;
   logic [31:0]       r_last_wdat;
   logic              r_tag_err;
   logic              r_rsp_err_seen;

   logic w_req_cand;
   logic w_rsp_hs;
   logic w_rsp_dec;

   // Outstanding can only reach 2**ITAG_W, so its MSB flags "all tags in use".
   assign w_req_cand    = ~w_empty & ~r_outstanding[ITAG_W] & ~eai_mem_holdup;
   // r_req_hold keeps a presented request up until it is taken, even if
   // holdup rises meanwhile; the head cannot move without a handshake.
   assign eai_req_valid = r_req_hold | w_req_cand;
   assign w_req_hs      = eai_req_valid & eai_req_ready;
   assign eai_req_itag  = r_issue_tag;

   assign eai_rsp_ready = (RSP_RDY_MODE != 0) ? eai_rsp_valid : ~eai_req_valid;
   assign w_rsp_hs      = eai_rsp_valid & eai_rsp_ready;
   // A spurious response (nothing outstanding) must not underflow the count.
   assign w_rsp_dec     = w_rsp_hs & (r_outstanding != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_tag    <= '0;
         r_retire_tag   <= '0;
         r_outstanding  <= '0;
         r_req_hold     <= 1'b0;
         r_rsp_count    <= '0;
         r_last_wdat    <= '0;
         r_tag_err      <= 1'b0;
         r_rsp_err_seen <= 1'b0;
      end else begin
         r_req_hold <= eai_req_valid & ~eai_req_ready;
         if (w_req_hs) r_issue_tag <= r_issue_tag + ITAG_W'(1);
         case ({w_req_hs, w_rsp_dec})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_rsp_hs) begin
            r_retire_tag <= r_retire_tag + ITAG_W'(1);
            r_rsp_count  <= r_rsp_count + 16'd1;
            r_last_wdat  <= eai_rsp_wdat;
            if ((eai_rsp_itag != r_retire_tag) || (r_outstanding == '0))
               r_tag_err <= 1'b1;
            if (eai_rsp_err)
               r_rsp_err_seen <= 1'b1;
         end
      end
   end

   assign outstanding   = r_outstanding;
   assign rsp_count     = r_rsp_count;
   assign last_rsp_wdat = r_last_wdat;
   assign tag_err       = r_tag_err;
   assign rsp_err_seen  = r_rsp_err_seen;

   // --------------------------------------------------------------- memory --
   logic [31:0]       r_mem [2**MEM_AW];
   mem_state_t        r_mem_state;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_icb_rsp_valid;
   logic [31:0]       r_icb_rdata;
   logic              r_icb_err;

   logic              w_cmd_hs;
   logic              w_addr_oor;
   logic [MEM_AW-1:0] w_word;
   logic              w_unused_addr;

   assign eai_icb_cmd_ready = (r_mem_state == S_IDLE) &&
                              ((CMD_RDY_MODE != 0) || eai_icb_cmd_valid);
   assign w_cmd_hs      = eai_icb_cmd_valid & eai_icb_cmd_ready;
   assign w_addr_oor    = |eai_icb_cmd_addr[31:MEM_AW+2];
   assign w_word        = eai_icb_cmd_addr[MEM_AW+1:2];
   // Byte offset within the word is deliberately ignored.
   assign w_unused_addr = ^eai_icb_cmd_addr[1:0];

   always_ff @(posedge clk) begin
      if (w_cmd_hs && !eai_icb_cmd_read && !w_addr_oor && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (eai_icb_cmd_wmask[i]) r_mem[w_word][8*i +: 8] <= eai_icb_cmd_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_state     <= S_IDLE;
         r_lat_cnt       <= '0;
         r_icb_rsp_valid <= 1'b0;
         r_icb_rdata     <= '0;
         r_icb_err       <= 1'b0;
      end else begin
         case (r_mem_state)
            S_IDLE: begin
               if (w_cmd_hs) begin
                  // Read data is captured at accept and held through RSP.
                  r_icb_rdata <= (eai_icb_cmd_read && !w_addr_oor) ? r_mem[w_word] : '0;
                  r_icb_err   <= w_addr_oor;
                  if (MEM_LAT == 1) begin
                     r_mem_state     <= S_RSP;
                     r_icb_rsp_valid <= 1'b1;
                  end else begin
                     r_mem_state <= S_WAIT;
                     r_lat_cnt   <= LAT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (r_lat_cnt == '0) begin
                  r_mem_state     <= S_RSP;
                  r_icb_rsp_valid <= 1'b1;
               end else begin
                  r_lat_cnt <= r_lat_cnt - LAT_W'(1);
               end
            end
            S_RSP: begin
               if (eai_icb_rsp_ready) begin
                  r_mem_state     <= S_IDLE;
                  r_icb_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_mem_state     <= S_IDLE;
               r_icb_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign eai_icb_rsp_valid = r_icb_rsp_valid;
   assign eai_icb_rsp_rdata = r_icb_rdata;
   assign eai_icb_rsp_err   = r_icb_err;

endmodule
